// File: rtl/kbd_line_ctrl_if.sv
// Bundle between the keyboard decoder, the line controller and the CPU MMIO port.
// Carries the decoder data_ready/read handshake and the committed-line handshake.
// The slave modport is the line controller's view; master is the driving side.
interface kbd_line_ctrl_if #(
    parameter int VAL_W = 16
);
    logic             kbd_ready;
    logic [7:0]       kbd_code;
    logic             kbd_released;
    logic             kbd_err;
    logic             kbd_read;
    logic [VAL_W-1:0] line_val;
    logic             line_valid;
    logic             line_ack;

    modport master (
        output kbd_ready, kbd_code, kbd_released, kbd_err, line_ack,
        input  kbd_read, line_val, line_valid
    );

    modport slave (
        input  kbd_ready, kbd_code, kbd_released, kbd_err, line_ack,
        output kbd_read, line_val, line_valid
    );
endinterface

// File: rtl/kbd_line_ctrl.sv
// kbd_line_ctrl: drains ASCII codes from the PS/2 decoder, edits a decimal digit
// line (digits, BACKSPACE, ENTER), converts it to binary on ENTER and holds the
// value for the CPU until acknowledged. Accepted characters are echoed with a
// one-cycle strobe for the display.
// Optional feature macro: KBD_ERR_CNT_EN adds a saturating err_cnt output that
// counts codes received with the decoder error flag set.
module kbd_line_ctrl #(
    parameter int MAX_DIGITS = 4,
    parameter int VAL_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    kbd_line_ctrl_if.slave        bus,
    output logic [2:0]            digit_cnt,
    output logic [7:0]            echo_char,
    output logic                  echo_stb,
    output logic                  busy
`ifdef KBD_ERR_CNT_EN
    ,
    output logic [7:0]            err_cnt
`endif
);

    localparam int         IDX_W   = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;
    localparam logic [2:0] CNT_MAX = 3'(MAX_DIGITS);
    localparam logic [7:0] CH_BS   = 8'h08;
    localparam logic [7:0] CH_CR   = 8'h0D;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_PROC,
        S_CONV,
        S_HOLD
    } state_t;

    state_t           state_reg;
    logic [7:0]       code_reg;
    logic             released_reg;
    logic             err_reg;
    logic [3:0]       digit_reg [MAX_DIGITS];
    logic [2:0]       digit_cnt_reg;
    logic [2:0]       idx_reg;
    logic [VAL_W-1:0] acc_reg;
    logic [VAL_W-1:0] line_val_reg;
    logic             line_valid_reg;
    logic             kbd_read_reg;
    logic [7:0]       echo_char_reg;
    logic             echo_stb_reg;
    logic             busy_reg;

    logic             is_digit;
    logic             key_ok;
    logic             push_en;
    logic             pop_en;
    logic             enter_en;
    logic             conv_last;
    logic [3:0]       conv_digit;
    logic [VAL_W-1:0] acc_next;
    logic [MAX_DIGITS-1:0] slot_wr;

    // Decode the latched key and the conversion step
    always_comb begin
        is_digit   = (code_reg >= 8'h30) && (code_reg <= 8'h39);
        key_ok     = (state_reg == S_PROC) && !released_reg && !err_reg;
        push_en    = key_ok && is_digit && (digit_cnt_reg < CNT_MAX);
        pop_en     = key_ok && (code_reg == CH_BS) && (digit_cnt_reg != 3'd0);
        enter_en   = key_ok && (code_reg == CH_CR) && (digit_cnt_reg != 3'd0);
        conv_digit = digit_reg[idx_reg[IDX_W-1:0]];
        acc_next   = acc_reg * VAL_W'(10) + VAL_W'(conv_digit);
        conv_last  = (idx_reg == (digit_cnt_reg - 3'd1));
    end

    // One write enable per buffer slot: a push lands at the current fill level
    generate
        for (genvar gi = 0; gi < MAX_DIGITS; gi++) begin : g_slot_wr
            assign slot_wr[gi] = push_en && (digit_cnt_reg[IDX_W-1:0] == IDX_W'(gi));
        end
    endgenerate

    // Digit buffer storage; popping only moves the fill level
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_DIGITS; i++) begin
                digit_reg[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < MAX_DIGITS; i++) begin
                if (slot_wr[i]) begin
                    digit_reg[i] <= code_reg[3:0];
                end
            end
        end
    end

    // Main sequencer: read handshake, line editing, conversion and CPU hold
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            code_reg       <= 8'd0;
            released_reg   <= 1'b0;
            err_reg        <= 1'b0;
            digit_cnt_reg  <= 3'd0;
            idx_reg        <= 3'd0;
            acc_reg        <= '0;
            line_val_reg   <= '0;
            line_valid_reg <= 1'b0;
            kbd_read_reg   <= 1'b0;
            echo_char_reg  <= 8'd0;
            echo_stb_reg   <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            echo_stb_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (bus.kbd_ready && !line_valid_reg) begin
                        code_reg     <= bus.kbd_code;
                        released_reg <= bus.kbd_released;
                        err_reg      <= bus.kbd_err;
                        kbd_read_reg <= 1'b1;
                        busy_reg     <= 1'b1;
                        state_reg    <= S_READ;
                    end
                end
                S_READ: begin
                    kbd_read_reg <= 1'b0;
                    state_reg    <= S_PROC;
                end
                S_PROC: begin
                    if (push_en || pop_en) begin
                        echo_char_reg <= code_reg;
                        echo_stb_reg  <= 1'b1;
                        digit_cnt_reg <= push_en ? digit_cnt_reg + 3'd1 : digit_cnt_reg - 3'd1;
                        busy_reg      <= 1'b0;
                        state_reg     <= S_IDLE;
                    end else if (enter_en) begin
                        echo_char_reg <= code_reg;
                        echo_stb_reg  <= 1'b1;
                        acc_reg       <= '0;
                        idx_reg       <= 3'd0;
                        state_reg     <= S_CONV;
                    end else begin
                        busy_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end
                S_CONV: begin
                    // The last digit's result goes straight to line_val to save a cycle
                    acc_reg <= acc_next;
                    if (conv_last) begin
                        line_val_reg   <= acc_next;
                        line_valid_reg <= 1'b1;
                        digit_cnt_reg  <= 3'd0;
                        state_reg      <= S_HOLD;
                    end else begin
                        idx_reg <= idx_reg + 3'd1;
                    end
                end
                S_HOLD: begin
                    if (bus.line_ack) begin
                        line_valid_reg <= 1'b0;
                        busy_reg       <= 1'b0;
                        state_reg      <= S_IDLE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

`ifdef KBD_ERR_CNT_EN
    logic [7:0] err_cnt_reg;

    // Saturating count of codes that arrived with the decoder error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_reg <= 8'd0;
        end else if ((state_reg == S_PROC) && err_reg && (err_cnt_reg != 8'hFF)) begin
            err_cnt_reg <= err_cnt_reg + 8'd1;
        end
    end

    assign err_cnt = err_cnt_reg;
`endif

    assign bus.kbd_read   = kbd_read_reg;
    assign bus.line_val   = line_val_reg;
    assign bus.line_valid = line_valid_reg;
    assign digit_cnt      = digit_cnt_reg;
    assign echo_char      = echo_char_reg;
    assign echo_stb       = echo_stb_reg;
    assign busy           = busy_reg;

endmodule

// File: tb/tb_kbd_line_ctrl.sv
// Testbench for kbd_line_ctrl: directed keystroke sequences followed by random
// keys, checked against a digit-queue model of the edited line.
module tb_kbd_line_ctrl;

    localparam int MAX_DIGITS = 4;
    localparam int VAL_W      = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    kbd_line_ctrl_if #(.VAL_W(VAL_W)) bus();

    logic [2:0] digit_cnt;
    logic [7:0] echo_char;
    logic       echo_stb;
    logic       busy;
`ifdef KBD_ERR_CNT_EN
    logic [7:0] err_cnt;
    int         exp_err_cnt = 0;
`endif

    kbd_line_ctrl #(.MAX_DIGITS(MAX_DIGITS), .VAL_W(VAL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .digit_cnt (digit_cnt),
        .echo_char (echo_char),
        .echo_stb  (echo_stb),
        .busy      (busy)
`ifdef KBD_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    int         checks = 0;
    int         errors = 0;
    int         model_q[$];
    logic [7:0] last_echo = 8'd0;
    bit         pend_next = 1'b0;
    logic [7:0] pend_code = 8'h33;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the read pulse, check its latency, then drop data_ready
    task automatic wait_read(input int exp_lat);
        int n = 0;
        bit seen = 1'b0;
        while (n < 20 && !seen) begin
            tick();
            n++;
            if (bus.kbd_read === 1'b1) seen = 1'b1;
        end
        check("read_seen", 32'(seen), 32'd1);
        if (seen) check("read_latency", 32'(n), 32'(exp_lat));
        bus.kbd_ready = 1'b0;
    endtask

    // Complete one key already presented on the bus and check the result
    task automatic process_key(input logic [7:0] code, input bit rel, input bit err, input int exp_lat);
        bit enter = 1'b0;
        bit exp_stb = 1'b0;
        int n = 0;
        int v = 0;
        int hold;
        wait_read(exp_lat);
        tick();
        check("read_width", 32'(bus.kbd_read), 32'd0);
        check("busy_proc", 32'(busy), 32'd1);
        tick();
        if (rel || err) begin
`ifdef KBD_ERR_CNT_EN
            if (err && exp_err_cnt < 255) exp_err_cnt++;
`endif
        end else if (code >= 8'h30 && code <= 8'h39) begin
            if (model_q.size() < MAX_DIGITS) begin
                model_q.push_back(int'(code) - 48);
                exp_stb = 1'b1;
            end
        end else if (code == 8'h08) begin
            if (model_q.size() > 0) begin
                void'(model_q.pop_back());
                exp_stb = 1'b1;
            end
        end else if (code == 8'h0D) begin
            if (model_q.size() > 0) begin
                exp_stb = 1'b1;
                enter = 1'b1;
                n = model_q.size();
                foreach (model_q[i]) v = v * 10 + model_q[i];
                model_q.delete();
            end
        end
        if (exp_stb) last_echo = code;
        check("echo_stb", 32'(echo_stb), 32'(exp_stb));
        check("echo_char", 32'(echo_char), 32'(last_echo));
        check("digit_cnt", 32'(digit_cnt), enter ? 32'(n) : 32'(model_q.size()));
        check("busy_after_proc", 32'(busy), 32'(enter));
`ifdef KBD_ERR_CNT_EN
        check("err_cnt", 32'(err_cnt), 32'(exp_err_cnt));
`endif
        $display("key code=%02h rel=%0d err=%0d -> digits=%0d echo_stb=%0d", code, rel, err, digit_cnt, echo_stb);
        if (enter) begin
            for (int i = 0; i < n; i++) begin
                check("line_valid_early", 32'(bus.line_valid), 32'd0);
                tick();
            end
            check("line_valid", 32'(bus.line_valid), 32'd1);
            check("line_val", 32'(bus.line_val), 32'(v));
            check("digit_cnt_cleared", 32'(digit_cnt), 32'd0);
            $display("line committed value=%0d expected=%0d", bus.line_val, v);
            hold = pend_next ? 3 : int'($urandom_range(0, 3));
            if (pend_next) begin
                bus.kbd_code     = pend_code;
                bus.kbd_released = 1'b0;
                bus.kbd_err      = 1'b0;
                bus.kbd_ready    = 1'b1;
            end
            for (int i = 0; i < hold; i++) begin
                tick();
                check("hold_valid", 32'(bus.line_valid), 32'd1);
                check("hold_no_read", 32'(bus.kbd_read), 32'd0);
            end
            bus.line_ack = 1'b1;
            tick();
            bus.line_ack = 1'b0;
            check("ack_clears_valid", 32'(bus.line_valid), 32'd0);
            check("ack_idle", 32'(busy), 32'd0);
            check("ack_no_read", 32'(bus.kbd_read), 32'd0);
        end
    endtask

    task automatic send_key(input logic [7:0] code, input bit rel, input bit err);
        bus.kbd_code     = code;
        bus.kbd_released = rel;
        bus.kbd_err      = err;
        bus.kbd_ready    = 1'b1;
        process_key(code, rel, err, 1);
    endtask

    initial begin
        logic [7:0] c;
        int r;
        rst = 1'b1;
        bus.kbd_ready = 1'b0;
        bus.kbd_code = 8'd0;
        bus.kbd_released = 1'b0;
        bus.kbd_err = 1'b0;
        bus.line_ack = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_read", 32'(bus.kbd_read), 32'd0);
        check("rst_valid", 32'(bus.line_valid), 32'd0);
        check("rst_val", 32'(bus.line_val), 32'd0);
        check("rst_digits", 32'(digit_cnt), 32'd0);
        check("rst_echo", 32'(echo_char), 32'd0);
        check("rst_stb", 32'(echo_stb), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // 1,2,3,ENTER -> 123
        send_key(8'h31, 0, 0); send_key(8'h32, 0, 0); send_key(8'h33, 0, 0); send_key(8'h0D, 0, 0);
        // 4,5,BS,7,ENTER -> 47
        send_key(8'h34, 0, 0); send_key(8'h35, 0, 0); send_key(8'h08, 0, 0);
        send_key(8'h37, 0, 0); send_key(8'h0D, 0, 0);
        // 9 x5, ENTER -> 9999
        for (int i = 0; i < 5; i++) send_key(8'h39, 0, 0);
        send_key(8'h0D, 0, 0);
        // empty-buffer ENTER/BACKSPACE, releases, errors, junk
        send_key(8'h0D, 0, 0); send_key(8'h08, 0, 0);
        send_key(8'h36, 1, 0); send_key(8'h36, 0, 1); send_key(8'h41, 0, 0);
        // key arriving while a line is pending is read only after the ack
        send_key(8'h38, 0, 0);
        pend_next = 1'b1;
        send_key(8'h0D, 0, 0);
        pend_next = 1'b0;
        process_key(pend_code, 0, 0, 1);
        send_key(8'h0D, 0, 0);

        // reset during conversion discards everything
        for (int i = 0; i < 4; i++) send_key(8'h32, 0, 0);
        bus.kbd_code = 8'h0D; bus.kbd_released = 1'b0; bus.kbd_err = 1'b0; bus.kbd_ready = 1'b1;
        wait_read(1);
        tick();
        tick();
        check("conv_echo", 32'(echo_stb), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_q.delete();
        last_echo = 8'd0;
`ifdef KBD_ERR_CNT_EN
        exp_err_cnt = 0;
`endif
        check("rstconv_valid", 32'(bus.line_valid), 32'd0);
        check("rstconv_digits", 32'(digit_cnt), 32'd0);
        check("rstconv_busy", 32'(busy), 32'd0);
        tick();
        check("rstconv_valid_after", 32'(bus.line_valid), 32'd0);
        $display("reset during conversion: valid=%0d digits=%0d busy=%0d", bus.line_valid, digit_cnt, busy);

        // random keys against the model
        for (int k = 0; k < 80; k++) begin
            r = int'($urandom_range(0, 99));
            if (r < 55) begin
                c = 8'(8'h30 + $urandom_range(0, 9));
                send_key(c, 0, 0);
            end else if (r < 67) begin
                send_key(8'h08, 0, 0);
            end else if (r < 77) begin
                send_key(8'h0D, 0, 0);
            end else if (r < 87) begin
                do c = 8'($urandom_range(0, 255));
                while ((c >= 8'h30 && c <= 8'h39) || c == 8'h08 || c == 8'h0D);
                send_key(c, 0, 0);
            end else begin
                c = 8'(8'h30 + $urandom_range(0, 9));
                if ($urandom_range(0, 1) == 0) send_key(c, 1, 0);
                else send_key(c, $urandom_range(0, 1) == 1, 1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
